mrhy4_s2p_decoder: RTL and testbench
====================================

// Module: mrhy4_s2p_decoder
// PURPOSE
//  Receiver/decoder for the mrHY4 serial digit stream that the butterfly datapath emits.
//  Each cycle one radix-4 digit {n2,p,pp} arrives, least-significant digit first.
//  Accumulates NDIG digits per frame into a parallel two's-complement word.
//  Presents each word on a valid/ready output towards the FIR output stage and host.
// PARAMETERS
//  NDIG  8           digits per frame; matches the 8-cycle butterfly frame
//  W     2*NDIG+1    output width (signed); holds max |value| = 2*(4^NDIG-1)/3
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  synchronous reset, active-high
//  in_valid   in   1  digit present this cycle
//  in_sof     in   1  start-of-frame: qualifies digit 0 (valid only with in_valid)
//  in_n2      in   1  digit weight -2 component
//  in_p       in   1  digit weight +1 component
//  in_pp      in   1  digit weight +1 component (second)
//  out_valid  out  1  out_data holds a completed, unconsumed word
//  out_ready  in   1  sink accepts word when out_valid&out_ready
//  out_data   out  W  decoded signed value
//  frame_err  out  1  one-cycle pulse on framing violation
//  overrun    out  1  sticky: completed word overwrote an unconsumed word
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, frame_err=0, overrun=0, digit idx=0, acc=0.
//  - Digit value: d = p + pp - 2*n2, range -2..+2; all 8 codes legal.
//  - Digit k contributes d*4^k (sign-extended to W); all arithmetic signed, no saturation.
//  - Digit index cnt (0..NDIG-1); cnt==0 means IDLE, waiting for sof.
//  - Per cycle with in_valid=1:
//    . in_sof=1: acc<=d, cnt<=1. If cnt!=0 (partial frame): discard it, pulse frame_err.
//    . in_sof=0, cnt==0: digit dropped, pulse frame_err, state unchanged.
//    . in_sof=0, 0<cnt<NDIG-1: acc<=acc+d*4^cnt, cnt<=cnt+1.
//    . in_sof=0, cnt==NDIG-1: out_data<=acc+d*4^cnt, out_valid<=1, cnt<=0, acc<=0.
//  - in_valid=0: no state change (digit gaps allowed mid-frame).
//  - Latency: out_valid rises on the edge that samples the last digit.
//    It is visible the cycle after that digit is presented.
//    With back-to-back digits: word visible NDIG cycles after sof presented.
//  - Handshake: word consumed on edge with out_valid&out_ready.
//    out_data is held stable while out_valid=1 and not consumed.
//  - Completion in the same cycle as consume: new word loads, out_valid stays 1, no overrun.
//  - Completion while out_valid=1 and out_ready=0: new word overwrites, overrun<=1.
//    overrun is cleared only by rst.
//  - NDIG=1: sof digit completes the frame immediately (cnt stays 0).
//  - rst mid-frame: partial frame discarded, pending output dropped, all to reset values.
//  - frame_err is a pulse; it does not block the outputs.
// TESTING
//  1 sof + 8 digits p=1 back-to-back, ready=1 -> out_data=21845, out_valid 1 cycle after digit 7.
//  2 8 digits n2=1,p=0,pp=0 -> out_data=-43690.
//    8 digits p=pp=1 -> +43690.
//    d0=1, d1=-1, rest 0 -> -3.
//  3 ready=0, two frames (1 then 2) -> out_data=2, overrun=1.
//    Raise ready -> 1-cycle consume; out_valid drops.
//  4 sof after 4 digits of a frame -> frame_err pulse, old partial discarded.
//    Next 8 digits (d=1 at k=0 only) -> out_data=1.
//  5 in_valid=1, in_sof=0 while idle -> frame_err pulse, no out_valid.
//    Random in_valid gaps inside a frame -> same result as gap-free.
//  6 rst asserted at digit 5 with a word pending -> out_valid=0, overrun=0.
//    Next clean frame decodes correctly.

Source files
------------

// File: rtl/mrhy4_s2p_decoder.sv
// Serial-to-parallel decoder for the mrHY4 radix-4 digit stream (LSD first).
// Each frame of NDIG digits becomes one signed word on a valid/ready output.
module mrhy4_s2p_decoder #(
  parameter int NDIG = 8,
  parameter int W    = 2*NDIG+1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic                in_n2,
  input  logic                in_p,
  input  logic                in_pp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                frame_err,
  output logic                overrun
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG-1);

  logic [CW-1:0]       cnt_reg, cnt_next;
  logic signed [W-1:0] acc_reg, acc_next;
  logic signed [W-1:0] data_reg, data_next;
  logic                valid_reg, valid_next;
  logic                err_reg, err_next;
  logic                ovr_reg, ovr_next;

  logic [2:0]          digit;
  logic signed [W-1:0] digit_ext;
  logic signed [W-1:0] weighted [NDIG];
  logic signed [W-1:0] word;
  logic                complete;
  logic                consume;

  // d = p + pp - 2*n2, computed modulo 8 and read as a signed 3-bit value
  assign digit     = 3'(in_p) + 3'(in_pp) - {1'b0, in_n2, 1'b0};
  assign digit_ext = {{(W-3){digit[2]}}, digit};
  assign consume   = valid_reg & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_weight
      assign weighted[gi] = digit_ext <<< (2*gi);
    end
  endgenerate

  always_comb begin
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    ovr_next   = ovr_reg;
    err_next   = 1'b0;
    complete   = 1'b0;
    word       = acc_reg + weighted[cnt_reg];

    if (in_valid) begin
      if (in_sof) begin
        // A new sof abandons any partial frame in progress
        err_next = (cnt_reg != '0);
        if (NDIG == 1) begin
          complete = 1'b1;
          word     = digit_ext;
        end else begin
          acc_next = digit_ext;
          cnt_next = CW'(1);
        end
      end else if (cnt_reg == '0) begin
        err_next = 1'b1;
      end else if (cnt_reg == LAST) begin
        complete = 1'b1;
        cnt_next = '0;
        acc_next = '0;
      end else begin
        acc_next = word;
        cnt_next = cnt_reg + CW'(1);
      end
    end

    if (complete) begin
      data_next  = word;
      valid_next = 1'b1;
      if (valid_reg && !out_ready)
        ovr_next = 1'b1;
    end else if (consume) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      acc_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign frame_err = err_reg;
  assign overrun   = ovr_reg;

endmodule

// File: tb/tb_mrhy4_s2p_decoder.sv
// Scoreboard bench for mrhy4_s2p_decoder: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted output.
module tb_mrhy4_s2p_decoder;

  localparam int NDIG = 8;
  localparam int W    = 2*NDIG+1;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, in_sof, in_n2, in_p, in_pp;
  logic                out_valid, out_ready;
  logic signed [W-1:0] out_data;
  logic                frame_err, overrun;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  mrhy4_s2p_decoder #(.NDIG(NDIG), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof),
    .in_n2(in_n2), .in_p(in_p), .in_pp(in_pp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      int e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %0d, expected none queued", out_data);
      end else begin
        e = exp_q.pop_front();
        if (int'(out_data) !== e) begin
          errors++;
          $display("FAIL word: got %0d, expected %0d", out_data, e);
        end else
          $display("word ok: %0d", out_data);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else
      $display("check ok %s: %0d", name, act);
  endtask

  // Drive one digit (code = {n2,p,pp}) across one rising edge; returns at posedge+1.
  task automatic digit(input bit sof, input logic [2:0] code);
    in_valid = 1'b1;
    in_sof   = sof;
    {in_n2, in_p, in_pp} = code;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Octal digit k of codes is the code of radix-4 digit k.
  task automatic send_frame(input logic [23:0] codes, input bit gaps);
    for (int k = 0; k < NDIG; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      digit(k == 0, codes[3*k +: 3]);
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_n2 = 1'b0; in_p = 1'b0; in_pp = 1'b0;
    idle(3);
    rst = 1'b0;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_err", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);

    // 1: all p=1, latency checked at digit 7 and 8
    exp_q.push_back(21845);
    for (int k = 0; k < NDIG; k++) begin
      digit(k == 0, 3'b010);
      if (k == NDIG-2) check("lat_before", int'(out_valid), 0);
      if (k == NDIG-1) check("lat_at", int'(out_valid), 1);
    end
    idle(1);
    check("valid_drop", int'(out_valid), 0);

    // 2: extremes and a mixed frame using alternate codes for 0 and +-1
    exp_q.push_back(-43690); send_frame(24'o44444444, 1'b0);
    exp_q.push_back(43690);  send_frame(24'o33333333, 1'b0);
    exp_q.push_back(-3);     send_frame(24'o77000751, 1'b0);
    idle(2);

    // 3: overrun with ready low; only the second word is consumed
    out_ready = 1'b0;
    send_frame(24'o00000002, 1'b0);
    send_frame(24'o00000003, 1'b0);
    idle(1);
    check("ovr_set", int'(overrun), 1);
    check("ovr_valid", int'(out_valid), 1);
    exp_q.push_back(2);
    out_ready = 1'b1;
    idle(1);
    check("ovr_consumed", int'(out_valid), 0);
    check("ovr_sticky", int'(overrun), 1);

    // 4: sof after a partial frame discards it
    for (int k = 0; k < 4; k++) digit(k == 0, 3'b011);
    digit(1'b1, 3'b001);
    check("sof_err", int'(frame_err), 1);
    for (int k = 1; k < NDIG; k++) digit(1'b0, 3'b000);
    check("sof_err_pulse", int'(frame_err), 0);
    exp_q.push_back(1);
    idle(2);

    // 5: stray digit while idle, then the same frame with and without gaps
    digit(1'b0, 3'b011);
    check("idle_err", int'(frame_err), 1);
    check("idle_novalid", int'(out_valid), 0);
    idle(1);
    check("idle_err_pulse", int'(frame_err), 0);
    exp_q.push_back(33309); send_frame(24'o37140362, 1'b1);
    idle(1);
    exp_q.push_back(33309); send_frame(24'o37140362, 1'b0);
    idle(2);

    // 6: reset mid-frame with a pending word
    out_ready = 1'b0;
    send_frame(24'o00000022, 1'b0);
    for (int k = 0; k < 5; k++) digit(k == 0, 3'b010);
    rst = 1'b1;
    digit(1'b0, 3'b010);
    rst = 1'b0;
    check("rst6_valid", int'(out_valid), 0);
    check("rst6_ovr", int'(overrun), 0);
    check("rst6_data", int'(out_data), 0);
    out_ready = 1'b1;
    exp_q.push_back(21845); send_frame(24'o22222222, 1'b0);

    // drain with a bounded wait
    begin
      int budget = 50;
      while (exp_q.size() != 0 && budget > 0) begin idle(1); budget--; end
      check("queue_drained", exp_q.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
